// File: rtl/inv_round_sequencer.sv
// -----------------------------------------------------------------------------
// inv_round_sequencer
//
// Purpose:
//   Sequences AES decryption round keys. The keys are issued from the expanded
//   key bus to the inverse round datapath, from the highest key (Nr) down to
//   key 0. Each key is presented with key_valid and held until the datapath
//   returns key_ack. A clocked FSM (IDLE -> ISSUE -> DONE) does the sequencing.
//   busy and done report progress to the top-level controller.
//
// Configuration macro:
//   INV_SEQ_ABORT_EN - when defined, adds the 'abort' input. Asserting abort
//                      while in ISSUE returns the block to IDLE with all
//                      outputs cleared and no done pulse. Abort wins over
//                      key_ack in the same cycle.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   start        begin a key sequence (sampled in IDLE only)
//   keySize      3'b001=128, 3'b010=192, 3'b100=256; any other value = 128
//   keyExp       expanded key, bits [0:EXP_W-1], key i = keyExp[128*i +: 128]
//   key_ack      datapath consumed the current key (ignored unless key_valid)
//   abort        (INV_SEQ_ABORT_EN only) cancel the running sequence
//   invNewKey    registered round key presented to the datapath
//   key_valid    invNewKey is valid
//   round_idx    index of the key currently presented
//   first_round  high with key Nr (initial AddRoundKey)
//   last_round   high with key 0
//   busy         sequence in progress
//   done         one-cycle pulse after key 0 is acknowledged
// -----------------------------------------------------------------------------
module inv_round_sequencer #(
    parameter int KEY_W = 128,
    parameter int EXP_W = 1920,
    parameter int IDX_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         keySize,
    input  logic [0:EXP_W-1]   keyExp,
    input  logic               key_ack,
`ifdef INV_SEQ_ABORT_EN
    input  logic               abort,
`endif
    output logic [KEY_W-1:0]   invNewKey,
    output logic               key_valid,
    output logic [IDX_W-1:0]   round_idx,
    output logic               first_round,
    output logic               last_round,
    output logic               busy,
    output logic               done
);

    localparam int NUM_KEYS = EXP_W / KEY_W;

    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(NUM_KEYS - 1);
    localparam logic [IDX_W-1:0] NR_128  = IDX_W'(10);
    localparam logic [IDX_W-1:0] NR_192  = IDX_W'(12);
    localparam logic [IDX_W-1:0] NR_256  = IDX_W'(14);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Round-key slicing. The bus is numbered ascending, so key i starts at
    // bit 128*i. The first bus bit of each key becomes the MSB of invNewKey.
    // -------------------------------------------------------------------------
    logic [KEY_W-1:0] round_keys [NUM_KEYS];

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key_slice
        assign round_keys[g] = keyExp[g*KEY_W +: KEY_W];
    end

    // An out-of-range index cannot occur in normal operation. The guard keeps
    // the key output at zero instead of reading past the bus.
    function automatic logic [KEY_W-1:0] select_key(input logic [IDX_W-1:0] idx);
        logic [KEY_W-1:0] key;
        key = '0;
        if (idx <= MAX_IDX) begin
            key = round_keys[idx];
        end
        return key;
    endfunction

    // Any keySize that is not an explicit 192 or 256 encoding runs as AES-128.
    function automatic logic [IDX_W-1:0] rounds_for(input logic [2:0] size);
        logic [IDX_W-1:0] nr;
        case (size)
            3'b010:  nr = NR_192;
            3'b100:  nr = NR_256;
            default: nr = NR_128;
        endcase
        return nr;
    endfunction

    // -------------------------------------------------------------------------
    // Abort qualifier. It is tied off when the feature is not built, so the
    // FSM below is the same in both configurations.
    // -------------------------------------------------------------------------
    logic abort_hit;
`ifdef INV_SEQ_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [KEY_W-1:0] key_q,   key_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic             valid_q, valid_d;
    logic             first_q, first_d;
    logic             last_q,  last_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the pre-edge value of its inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            first_q <= first_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    logic [IDX_W-1:0] nr_sel;
    logic [IDX_W-1:0] idx_dec;

    // NOTE: every signal is given a default before the case statement.
    // This makes each path assign every output, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        first_d = first_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        nr_sel  = rounds_for(keySize);
        idx_dec = idx_q - 1'b1;

        case (state_q)
            IDLE: begin
                // The round count is captured only here. Later keySize
                // changes have no effect until the next start.
                if (start) begin
                    state_d = ISSUE;
                    idx_d   = nr_sel;
                    key_d   = select_key(nr_sel);
                    valid_d = 1'b1;
                    first_d = 1'b1;
                    last_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            ISSUE: begin
                if (abort_hit) begin
                    state_d = IDLE;
                    key_d   = '0;
                    idx_d   = '0;
                    valid_d = 1'b0;
                    first_d = 1'b0;
                    last_d  = 1'b0;
                    busy_d  = 1'b0;
                end else if (key_ack) begin
                    if (idx_q != '0) begin
                        // The next key goes out on the edge that retires the
                        // current one, so with ack held high key_valid
                        // stays up and one key is issued per cycle.
                        idx_d   = idx_dec;
                        key_d   = select_key(idx_dec);
                        first_d = 1'b0;
                        last_d  = (idx_dec == '0);
                    end else begin
                        state_d = DONE;
                        key_d   = '0;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end

            DONE: begin
                // A single-cycle state. start is not looked at here, so a
                // start during the done pulse cannot re-launch a sequence.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                key_d   = '0;
                idx_d   = '0;
                valid_d = 1'b0;
                first_d = 1'b0;
                last_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign invNewKey   = key_q;
    assign key_valid   = valid_q;
    assign round_idx   = idx_q;
    assign first_round = first_q;
    assign last_round  = last_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_inv_round_sequencer.sv
// -----------------------------------------------------------------------------
// tb_inv_round_sequencer
//
// Self-checking bench for inv_round_sequencer. Each scenario fills the
// expanded-key bus with random round keys. The reference model is the
// expected key order: Nr down to 0, with Nr taken from keySize. Each key is
// held for a chosen number of stall cycles before it is acknowledged. The
// outputs are sampled on the falling edge and compared as one packed word.
// With INV_SEQ_ABORT_EN defined, the abort scenario is also exercised.
// -----------------------------------------------------------------------------
module tb_inv_round_sequencer;

    localparam int KEY_W    = 128;
    localparam int EXP_W    = 1920;
    localparam int IDX_W    = 4;
    localparam int NUM_KEYS = EXP_W / KEY_W;
    localparam int OBS_W    = 1 + IDX_W + 4 + KEY_W;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [2:0]         keySize;
    logic [0:EXP_W-1]   keyExp;
    logic               key_ack;
`ifdef INV_SEQ_ABORT_EN
    logic               abort;
`endif
    logic [KEY_W-1:0]   invNewKey;
    logic               key_valid;
    logic [IDX_W-1:0]   round_idx;
    logic               first_round;
    logic               last_round;
    logic               busy;
    logic               done;

    int total = 0;
    int bad   = 0;

    logic [KEY_W-1:0] keys [NUM_KEYS];

    inv_round_sequencer #(
        .KEY_W (KEY_W),
        .EXP_W (EXP_W),
        .IDX_W (IDX_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .keySize     (keySize),
        .keyExp      (keyExp),
        .key_ack     (key_ack),
`ifdef INV_SEQ_ABORT_EN
        .abort       (abort),
`endif
        .invNewKey   (invNewKey),
        .key_valid   (key_valid),
        .round_idx   (round_idx),
        .first_round (first_round),
        .last_round  (last_round),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Packs the output set in one fixed order: valid, idx, first, last,
    // busy, done, key.
    function automatic logic [OBS_W-1:0] pack_obs(input logic v, input int idx,
                                                  input logic f, input logic l,
                                                  input logic b, input logic d,
                                                  input logic [KEY_W-1:0] key);
        return {v, IDX_W'(idx), f, l, b, d, key};
    endfunction

    function automatic logic [OBS_W-1:0] observed();
        return {key_valid, round_idx, first_round, last_round, busy, done, invNewKey};
    endfunction

    // Expected round count, taken straight from the key-size table.
    function automatic int expected_nr(input logic [2:0] ks);
        if (ks == 3'b010) return 12;
        if (ks == 3'b100) return 14;
        return 10;
    endfunction

    task automatic new_keys();
        for (int i = 0; i < NUM_KEYS; i++) begin
            keys[i] = {$urandom, $urandom, $urandom, $urandom};
            keyExp[i*KEY_W +: KEY_W] = keys[i];
        end
    endtask

    task automatic test_reset();
        logic [OBS_W-1:0] got, want;
        want = pack_obs(0, 0, 0, 0, 0, 0, '0);
        #1;
        got = observed();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL reset_state: got=%h want=%h", got, want);
        end
        start   = 1'b1;
        key_ack = 1'b1;
        repeat (2) @(negedge clk);
        got = observed();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL reset_ignores_start: got=%h want=%h", got, want);
        end
        start   = 1'b0;
        key_ack = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        got = observed();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL idle_after_release: got=%h want=%h", got, want);
        end
    endtask

    // Runs a whole sequence. stall_mode >= 0 holds each key for that many
    // extra cycles; a negative value picks a random stall of 0..3 per key.
    // When noisy is set, start and keySize are toggled at random while busy.
    task automatic test_sequence(input string name, input logic [2:0] ks,
                                 input int stall_mode, input bit noisy);
        logic [OBS_W-1:0] got, want;
        int nr, stall;
        new_keys();
        nr = expected_nr(ks);
        @(negedge clk);
        keySize = ks;
        start   = 1'b1;
        key_ack = 1'b0;
        @(posedge clk);
        for (int k = nr; k >= 0; k--) begin
            stall = (stall_mode < 0) ? int'($urandom_range(0, 3)) : stall_mode;
            for (int s = 0; s <= stall; s++) begin
                @(negedge clk);
                got  = observed();
                want = pack_obs(1, k, k == nr, k == 0, 1, 0, keys[k]);
                total++;
                if (got !== want) begin
                    bad++;
                    $display("FAIL %s key%0d hold%0d: got=%h want=%h", name, k, s, got, want);
                end
                start   = noisy ? 1'($urandom) : 1'b0;
                keySize = noisy ? 3'($urandom) : ks;
                key_ack = (s == stall);
            end
            @(posedge clk);
        end
        @(negedge clk);
        got  = observed();
        want = pack_obs(0, 0, 0, 0, 0, 1, '0);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s done_pulse: got=%h want=%h", name, got, want);
        end
        // A start during the done cycle must not re-launch.
        start   = 1'b1;
        key_ack = 1'($urandom);
        @(negedge clk);
        got  = observed();
        want = pack_obs(0, 0, 0, 0, 0, 0, '0);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s idle_after_done: got=%h want=%h", name, got, want);
        end
        start   = 1'b0;
        key_ack = 1'b0;
    endtask

    task automatic test_reset_mid_sequence();
        logic [OBS_W-1:0] got, want;
        new_keys();
        @(negedge clk);
        keySize = 3'b001;
        start   = 1'b1;
        key_ack = 1'b0;
        @(posedge clk);
        for (int k = 10; k >= 5; k--) begin
            @(negedge clk);
            start = 1'b0;
            got   = observed();
            want  = pack_obs(1, k, k == 10, 0, 1, 0, keys[k]);
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL rst_mid key%0d: got=%h want=%h", k, got, want);
            end
            key_ack = (k != 5);
            if (k != 5) @(posedge clk);
        end
        #1 rst = 1'b0;
        #1;
        got  = observed();
        want = pack_obs(0, 0, 0, 0, 0, 0, '0);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL rst_mid_async_clear: got=%h want=%h", got, want);
        end
        key_ack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            got = observed();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL rst_mid_held: got=%h want=%h", got, want);
            end
        end
        rst = 1'b1;
        test_sequence("rst_mid_restart", 3'b001, 0, 0);
    endtask

`ifdef INV_SEQ_ABORT_EN
    task automatic test_abort();
        logic [OBS_W-1:0] got, want;
        new_keys();
        @(negedge clk);
        keySize = 3'b001;
        start   = 1'b1;
        key_ack = 1'b0;
        @(posedge clk);
        for (int k = 10; k >= 7; k--) begin
            @(negedge clk);
            start = 1'b0;
            got   = observed();
            want  = pack_obs(1, k, k == 10, 0, 1, 0, keys[k]);
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL abort_pre key%0d: got=%h want=%h", k, got, want);
            end
            key_ack = 1'b1;
            abort   = (k == 7);
            @(posedge clk);
        end
        @(negedge clk);
        abort   = 1'b0;
        key_ack = 1'b0;
        want    = pack_obs(0, 0, 0, 0, 0, 0, '0);
        got     = observed();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL abort_cleared: got=%h want=%h", got, want);
        end
        @(negedge clk);
        got = observed();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL abort_no_done: got=%h want=%h", got, want);
        end
        test_sequence("abort_restart", 3'b001, 0, 0);
    endtask
`endif

    initial begin
        logic [2:0] sizes [4];
        rst     = 1'b0;
        start   = 1'b0;
        key_ack = 1'b0;
        keySize = 3'b001;
        keyExp  = '0;
`ifdef INV_SEQ_ABORT_EN
        abort   = 1'b0;
`endif
        sizes[0] = 3'b001;
        sizes[1] = 3'b010;
        sizes[2] = 3'b100;
        sizes[3] = 3'b011;

        test_reset();
        test_sequence("aes128_ack_high", 3'b001, 0, 0);
        test_sequence("aes256_ack_high", 3'b100, 0, 0);
        test_sequence("aes192_stall3",   3'b010, 3, 0);
        test_sequence("keysize_000",     3'b000, -1, 1);
        test_sequence("keysize_111",     3'b111, -1, 1);
        for (int i = 0; i < 4; i++) begin
            test_sequence("back_to_back", sizes[$urandom_range(0, 3)], -1, 1);
        end
        test_reset_mid_sequence();
`ifdef INV_SEQ_ABORT_EN
        test_abort();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inv_round_sequencer.md
Name: inv_round_sequencer

Overview:
Sequences AES decryption by issuing round keys from the expanded-key bus to the inverse round datapath, from the highest round key down to key 0. It replaces edge-triggered key stepping with a clocked FSM and a valid/ack handshake. Round count comes from keySize. It sits between the key expansion unit and the inverse round datapath, and reports start/busy/done to the top-level controller.

Parameters:
KEY_W, 128, width of one round key in bits
EXP_W, 1920, width of expanded-key bus (15 round keys × 128)
IDX_W, 4, width of round index

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  begin a decryption key sequence; sampled in IDLE only
keySize  input  3  3'b001=128-bit, 3'b010=192-bit, 3'b100=256-bit; any other value treated as 128-bit
keyExp  input  EXP_W  expanded key, bits [0:EXP_W-1]; round key i = keyExp[128*i : 128*i+127]; must be stable while busy
key_ack  input  1  datapath has consumed current round key
invNewKey  output  KEY_W  registered round key to the inverse datapath
key_valid  output  1  invNewKey valid
round_idx  output  IDX_W  index of the key currently presented
first_round  output  1  high with the initial AddRoundKey key (idx = Nr)
last_round  output  1  high with the final key (idx = 0)
busy  output  1  sequence in progress
done  output  1  one-cycle pulse after key 0 is acknowledged

Behaviour:
- Reset (rst=0, async): state=IDLE. invNewKey=0, key_valid=0, round_idx=0, first_round=0, last_round=0, busy=0, done=0.
- Nr from keySize latched at start: 128→10, 192→12, 256→14. keySize changes while busy are ignored.
- States:
  - IDLE: busy=0, key_valid=0. If start=1 at an edge: latch Nr, load invNewKey=key Nr, round_idx=Nr, first_round=1, key_valid=1, busy=1; go to ISSUE. Latency from start edge to key_valid is 1 cycle.
  - ISSUE: hold all outputs until key_ack=1 at an edge. On ack with round_idx>0: round_idx-=1, load the new key, first_round=0, last_round=(new idx==0); stay in ISSUE. On ack with round_idx==0: key_valid=0, last_round=0, invNewKey=0; go to DONE.
  - DONE: done=1 for exactly this cycle, busy=0; go to IDLE unconditionally.
- Throughput: with key_ack held high, one key per cycle. key_valid stays high across consecutive keys.
- key_ack is ignored when key_valid=0. start is ignored outside IDLE, including in the DONE cycle.
- Round-index arithmetic is unsigned IDX_W bits. The decrement never wraps because exit occurs at idx 0.
- Key select uses 128*round_idx. An index above 14 cannot occur; if it does, invNewKey=0.
- Reset asserted mid-sequence aborts immediately with no done pulse. After release, the FSM is in IDLE.

Optional Feature:
INV_SEQ_ABORT_EN
- Defined: adds input abort (1 bit). abort=1 at an edge in ISSUE returns to IDLE next cycle. Clears key_valid, invNewKey, round_idx, first_round, last_round, busy, with no done pulse. Abort takes priority over key_ack in the same cycle and is ignored in IDLE/DONE.
- Undefined: the port is absent; a sequence ends only via completion or reset.

Test Plan:
- 128-bit, key_ack tied high, start at edge 0 → key_valid at cycles 1–11, round_idx 10..0, invNewKey=keyExp[1280:1407] first and keyExp[0:127] last; first_round only at cycle 1, last_round only at cycle 11; done pulse at cycle 12; busy low at cycle 12.
- 256-bit, ack high → 15 keys, first = keyExp[1792:1919] with round_idx=14; done 16 cycles after start.
- 192-bit, key_ack low for 3 cycles on each key → each key held 4 cycles with outputs stable; 13 keys total, first = keyExp[1536:1663]; exactly one done pulse.
- keySize=3'b000 and 3'b111 → identical to 128-bit (11 keys); start pulsed while busy and during DONE → no restart, no change to round_idx.
- rst low at round_idx=5 → all outputs 0 asynchronously, no done pulse; new start after release → full 128-bit sequence from idx 10.
- INV_SEQ_ABORT_EN: abort with key_ack at idx 7 → idle next cycle, no done, idx not decremented; subsequent start works normally.
